piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a one-entry hold buffer.
// Serializes WIDTH-bit words MSB first, one bit per cycle, back-to-back frames.
//
// Parameters:
//   WIDTH       parallel word width in bits (2..32)
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   datain      parallel word to serialize
//   load_valid  sender has a valid word on datain
//   load_ready  block can accept a word this cycle (hold buffer empty)
//   dataout     serial output bit (0 whenever dout_valid is low)
//   dout_valid  dataout carries a frame bit
//   busy        state is not IDLE
//   frame_done  pulse with the last bit of a frame on dataout
// Build option:
//   PISO_PARITY_EN  when defined, each frame ends with an even-parity bit
//                   (XOR of the frame's word), giving WIDTH+1 bits per frame.

module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dataout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             last_data;
    logic             nxt_load;
    logic [WIDTH-1:0] nxt_word;

    // The hold buffer is the only storage for a pending word, so the
    // block is ready exactly when that buffer is empty.
    assign load_ready = ~hold_full_q;
    assign accept     = load_valid & load_ready;
    assign last_data  = (state_q == SHIFT) && (cnt_q == LAST);

    // Word that starts the next frame at a frame boundary: a buffered
    // word has priority; otherwise one accepted in this very cycle.
    // Both can never be present at once because accept needs an
    // empty buffer.
    assign nxt_load = hold_full_q | accept;
    assign nxt_word = hold_full_q ? hold_q : datain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
`ifdef PISO_PARITY_EN
        par_d       = par_q;
`endif
        dataout     = 1'b0;
        dout_valid  = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = datain;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = ^datain;
`endif
                end
            end

            SHIFT: begin
                dout_valid = 1'b1;
                busy       = 1'b1;
                dataout    = shreg_q[WIDTH-1];
                shreg_d    = shreg_q << 1;
                cnt_d      = cnt_q + CW'(1);
`ifdef PISO_PARITY_EN
                // Data bits are done; the parity bit still follows, so a
                // word offered now waits in the hold buffer.
                if (last_data) begin
                    state_d = PARITY;
                    cnt_d   = '0;
                end
                if (accept) begin
                    hold_d      = datain;
                    hold_full_d = 1'b1;
                end
`else
                if (last_data) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    if (nxt_load) begin
                        state_d     = SHIFT;
                        shreg_d     = nxt_word;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    hold_d      = datain;
                    hold_full_d = 1'b1;
                end
`endif
            end

`ifdef PISO_PARITY_EN
            PARITY: begin
                dout_valid = 1'b1;
                busy       = 1'b1;
                dataout    = par_q;
                frame_done = 1'b1;
                cnt_d      = '0;
                if (nxt_load) begin
                    state_d     = SHIFT;
                    shreg_d     = nxt_word;
                    par_d       = ^nxt_word;
                    hold_full_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                hold_full_d = 1'b0;
            end
        endcase
    end

endmodule
